collision_manager: RTL and testbench
====================================

Name: collision_manager

Overview:
- Consumer end of the per-object draw-request interface. It takes draw requests and RGB from the smiley, flipper and borders objects.
- It drives the on-screen pixel colour through a priority RGB mux.
- It also drives the collision pulses that the smiley controller consumes: collisionSmileyBorders and collisionSmileyFlipper.
- It sits between the object blocks and the VGA output.
- It enforces a limit of one collision pulse per frame, and a frame-count holdoff on flipper hits so the ball cannot stick to the flipper.

Parameters:
- HOLDOFF_FRAMES, 4: frames during which further flipper collisions are suppressed after a flipper pulse. 0 disables the holdoff.
- COUNT_W, 8: width of the saturating flipper-hit counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- draw_smiley  in  1  smiley draw request for the current pixel
- RGB_smiley  in  8  smiley pixel colour
- draw_flipper  in  1  flipper draw request
- RGB_flipper  in  8  flipper pixel colour
- draw_borders  in  1  borders draw request
- RGB_borders  in  8  borders pixel colour
- RGB_background  in  8  background colour
- RGBOut  out  8  final pixel colour, registered
- collisionSmileyBorders  out  1  one-cycle collision pulse
- collisionSmileyFlipper  out  1  one-cycle collision pulse
- frameCollisions  out  2  {flipper, borders}: collisions seen during the previous frame
- flipperHitCount  out  COUNT_W  saturating count of issued flipper pulses

Behaviour:
- Reset: all outputs are 0. Per-frame flags, holdoff counter and hit counter are cleared. The flipper FSM is in ARMED.
- RGB mux:
  - Priority is smiley > flipper > borders > background.
  - RGBOut is registered: latency 1 clk from the inputs.
- Overlap terms, combinational:
  - ovB = draw_smiley & draw_borders
  - ovF = draw_smiley & draw_flipper
- Borders path:
  - collisionSmileyBorders = 1 for exactly the cycle after the first ovB cycle in a frame.
  - The per-frame flag bordersSeen is then set and blocks further pulses until the next startOfFrame.
- Flipper FSM has two states:
  - ARMED: on ovF with flipperSeen = 0, pulse collisionSmileyFlipper the next cycle, set flipperSeen, load holdoff counter with HOLDOFF_FRAMES, and go to HOLDOFF. If HOLDOFF_FRAMES = 0, stay in ARMED instead.
  - HOLDOFF: ovF is ignored. The counter decrements on each startOfFrame. When the counter reaches 0 on a startOfFrame, return to ARMED.
  - Net effect of HOLDOFF = 4: suppression covers the rest of the hit frame plus the next 3 frames. A new pulse is possible in frame hit+4.
- startOfFrame cycle:
  - frameCollisions <= {flipperSeen, bordersSeen}, capturing values before the clear.
  - Then both flags are cleared.
  - An overlap in the same cycle as startOfFrame belongs to the new frame: it may pulse and sets the new-frame flag. The overlap is not included in the captured frameCollisions.
- Simultaneous ovB and ovF, both eligible: both pulses fire in the same cycle.
- flipperHitCount increments by 1 per issued flipper pulse and saturates at 2^COUNT_W-1. It is never cleared except by reset.
- Reset asserted mid-frame: clears everything at the next clk edge. Pulses in flight are dropped. The first frame after reset is fully armed.
- Draw requests outside overlap have no effect on the collision logic.

Decomposition:
- Shared package pinball_pkg holds:
  - RGB_W = 8
  - enum flipper_state_t {ARMED, HOLDOFF}
  - priority-order constants for the RGB mux
- One natural sub-module is frame_oneshot: per-frame flag plus registered one-cycle pulse, cleared by startOfFrame. It is instantiated twice, for borders and flipper. The flipper instance is gated by the FSM.
- The RGB mux stays inline.

Test Plan:
- Reset, then RGB_smiley = 8'hE0 with draw_smiley = 1 and all other draws 0 -> RGBOut = 8'hE0 one clk later. With draw_smiley = 0 and draw_borders = 1, RGB_borders = 8'h1F -> RGBOut = 8'h1F. With no draw requests -> RGBOut = RGB_background.
- ovB held for 10 consecutive cycles within one frame -> exactly one collisionSmileyBorders pulse, on the cycle after the first overlap. At the next startOfFrame, frameCollisions = 2'b01.
- HOLDOFF_FRAMES = 4, ovF every frame for 8 frames -> flipper pulses only in frames 0 and 4. flipperHitCount = 2. The FSM is in HOLDOFF during frames 1-3 and 5-7.
- ovB and ovF in the same cycle in a fresh frame -> both pulses high in the same cycle. The next frameCollisions = 2'b11.
- Overlap coinciding with startOfFrame, after an earlier overlap in the old frame -> a pulse is issued for the new frame. The captured frameCollisions reflects only the old frame.
- Reset asserted mid-HOLDOFF with count = 100 -> next cycle: all outputs 0, FSM in ARMED. The next ovF pulses immediately. COUNT_W = 2 with 5 eligible hits -> flipperHitCount saturates at 3.

Source files
------------

// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball object/collision path.
//   RGB_W            : pixel colour width (RRRGGGBB)
//   flipper_state_t  : flipper collision FSM states
//   rgb_src_t        : RGB mux sources, declared in priority order
//   pick_src()       : priority encoder over the per-object draw requests
package pinball_pkg;

  localparam int RGB_W = 8;

  typedef enum logic {
    ARMED   = 1'b0,
    HOLDOFF = 1'b1
  } flipper_state_t;

  // Declaration order is the priority order: earlier entries win.
  typedef enum logic [1:0] {
    SRC_SMILEY     = 2'd0,
    SRC_FLIPPER    = 2'd1,
    SRC_BORDERS    = 2'd2,
    SRC_BACKGROUND = 2'd3
  } rgb_src_t;

  function automatic rgb_src_t pick_src(input logic draw_smiley,
                                        input logic draw_flipper,
                                        input logic draw_borders);
    if (draw_smiley)       return SRC_SMILEY;
    else if (draw_flipper) return SRC_FLIPPER;
    else if (draw_borders) return SRC_BORDERS;
    else                   return SRC_BACKGROUND;
  endfunction

endpackage

// File: rtl/frame_oneshot.sv
// Per-frame collision one-shot: the first trigger in a frame produces a
// single registered pulse; the 'seen' flag then blocks further pulses until
// the next start_of_frame.
//   clk, reset      : clock, synchronous active-high reset
//   start_of_frame  : one-cycle frame start; clears the flag
//   trigger         : qualified overlap for this collision type
//   fire            : combinational, a pulse is being issued this cycle
//   seen            : collision already pulsed in the current frame
//   pulse           : registered one-cycle collision pulse
module frame_oneshot (
  input  logic clk,
  input  logic reset,
  input  logic start_of_frame,
  input  logic trigger,
  output logic fire,
  output logic seen,
  output logic pulse
);

  // A trigger on the start_of_frame cycle belongs to the new frame, so the
  // old flag must not block it.
  assign fire = trigger & (start_of_frame | ~seen);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= fire;
      seen  <= fire | (seen & ~start_of_frame);
    end
  end

endmodule

// File: rtl/collision_manager.sv
// Collision manager: consumes draw requests and colours from the smiley,
// flipper and borders objects, drives the registered priority RGB mux toward
// VGA, and issues at most one smiley/borders and one smiley/flipper collision
// pulse per frame. After a flipper pulse, further flipper hits are suppressed
// for HOLDOFF_FRAMES frame starts so the ball cannot stick to the flipper.
//   clk, reset               : clock, synchronous active-high reset
//   startOfFrame             : one-cycle pulse at each frame start
//   draw_*/RGB_*             : per-object draw request and colour
//   RGB_background           : colour when nothing draws
//   RGBOut                   : registered pixel colour (1 clk latency)
//   collisionSmileyBorders   : one-cycle pulse, first smiley/borders overlap
//   collisionSmileyFlipper   : one-cycle pulse, eligible smiley/flipper overlap
//   frameCollisions          : {flipper, borders} seen in the previous frame
//   flipperHitCount          : saturating count of issued flipper pulses
module collision_manager
  import pinball_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 4,
  parameter int COUNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               draw_smiley,
  input  logic [RGB_W-1:0]   RGB_smiley,
  input  logic               draw_flipper,
  input  logic [RGB_W-1:0]   RGB_flipper,
  input  logic               draw_borders,
  input  logic [RGB_W-1:0]   RGB_borders,
  input  logic [RGB_W-1:0]   RGB_background,
  output logic [RGB_W-1:0]   RGBOut,
  output logic               collisionSmileyBorders,
  output logic               collisionSmileyFlipper,
  output logic [1:0]         frameCollisions,
  output logic [COUNT_W-1:0] flipperHitCount
);

  localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_FRAMES);

  // ---------------------------------------------------------------------------
  // RGB priority mux, registered
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0] rgb_next;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rgb_next = RGB_background;
    unique case (pick_src(draw_smiley, draw_flipper, draw_borders))
      SRC_SMILEY:     rgb_next = RGB_smiley;
      SRC_FLIPPER:    rgb_next = RGB_flipper;
      SRC_BORDERS:    rgb_next = RGB_borders;
      SRC_BACKGROUND: rgb_next = RGB_background;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) RGBOut <= '0;
    else       RGBOut <= rgb_next;
  end

  // ---------------------------------------------------------------------------
  // Overlap detection
  // ---------------------------------------------------------------------------
  logic ov_b, ov_f;
  assign ov_b = draw_smiley & draw_borders;
  assign ov_f = draw_smiley & draw_flipper;

  // ---------------------------------------------------------------------------
  // Flipper holdoff FSM
  // ---------------------------------------------------------------------------
  flipper_state_t    state, state_next;
  logic [HOLD_W-1:0] holdoff_cnt, holdoff_next;
  logic              flip_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARMED;
      holdoff_cnt <= '0;
    end else begin
      state       <= state_next;
      holdoff_cnt <= holdoff_next;
    end
  end

  always_comb begin
    state_next   = state;
    holdoff_next = holdoff_cnt;
    unique case (state)
      ARMED: begin
        // With no holdoff configured the per-frame flag alone limits hits.
        if (flip_fire && (HOLDOFF_FRAMES != 0)) begin
          state_next   = HOLDOFF;
          holdoff_next = HOLD_LOAD;
        end
      end
      HOLDOFF: begin
        if (startOfFrame) begin
          // A counter at or below 1 reaches 0 on this frame start.
          if (holdoff_cnt <= HOLD_W'(1)) begin
            state_next   = ARMED;
            holdoff_next = '0;
          end else begin
            holdoff_next = holdoff_cnt - HOLD_W'(1);
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-frame one-shots
  // ---------------------------------------------------------------------------
  logic bord_fire, bord_seen, flip_seen;

  frame_oneshot u_borders (
    .clk            (clk),
    .reset          (reset),
    .start_of_frame (startOfFrame),
    .trigger        (ov_b),
    .fire           (bord_fire),
    .seen           (bord_seen),
    .pulse          (collisionSmileyBorders)
  );

  // Flipper overlaps only count while the FSM is armed.
  frame_oneshot u_flipper (
    .clk            (clk),
    .reset          (reset),
    .start_of_frame (startOfFrame),
    .trigger        (ov_f & (state == ARMED)),
    .fire           (flip_fire),
    .seen           (flip_seen),
    .pulse          (collisionSmileyFlipper)
  );

  // ---------------------------------------------------------------------------
  // Previous-frame summary and saturating hit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      frameCollisions <= 2'b00;
      flipperHitCount <= '0;
    end else begin
      // Flags are sampled before the one-shots clear them on this edge.
      if (startOfFrame)
        frameCollisions <= {flip_seen, bord_seen};
      if (flip_fire && (flipperHitCount != {COUNT_W{1'b1}}))
        flipperHitCount <= flipperHitCount + COUNT_W'(1);
    end
  end

  // Only the registered pulse leaves the block; the early fire term is
  // kept as a one-shot output for symmetry with the flipper instance.
  logic unused_bord_fire;
  assign unused_bord_fire = bord_fire;

endmodule

// File: tb/tb_collision_manager.sv
// Directed bench for collision_manager: main instance (HOLDOFF_FRAMES = 4,
// COUNT_W = 8) plus a saturation instance (HOLDOFF_FRAMES = 0, COUNT_W = 2)
// driven from the same stimulus.
module tb_collision_manager;
  import pinball_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       draw_smiley = 1'b0, draw_flipper = 1'b0, draw_borders = 1'b0;
  logic [7:0] RGB_smiley = 8'hE0, RGB_flipper = 8'h1C, RGB_borders = 8'h1F;
  logic [7:0] RGB_background = 8'h03;

  logic [7:0] rgb_out;
  logic       col_b, col_f;
  logic [1:0] frame_col;
  logic [7:0] hit_cnt;

  logic [7:0] s_rgb;
  logic       s_col_b, s_col_f;
  logic [1:0] s_frame;
  logic [1:0] s_cnt;

  collision_manager #(.HOLDOFF_FRAMES(4), .COUNT_W(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .startOfFrame           (startOfFrame),
    .draw_smiley            (draw_smiley),
    .RGB_smiley             (RGB_smiley),
    .draw_flipper           (draw_flipper),
    .RGB_flipper            (RGB_flipper),
    .draw_borders           (draw_borders),
    .RGB_borders            (RGB_borders),
    .RGB_background         (RGB_background),
    .RGBOut                 (rgb_out),
    .collisionSmileyBorders (col_b),
    .collisionSmileyFlipper (col_f),
    .frameCollisions        (frame_col),
    .flipperHitCount        (hit_cnt)
  );

  collision_manager #(.HOLDOFF_FRAMES(0), .COUNT_W(2)) dut_sat (
    .clk                    (clk),
    .reset                  (reset),
    .startOfFrame           (startOfFrame),
    .draw_smiley            (draw_smiley),
    .RGB_smiley             (RGB_smiley),
    .draw_flipper           (draw_flipper),
    .RGB_flipper            (RGB_flipper),
    .draw_borders           (draw_borders),
    .RGB_borders            (RGB_borders),
    .RGB_background         (RGB_background),
    .RGBOut                 (s_rgb),
    .collisionSmileyBorders (s_col_b),
    .collisionSmileyFlipper (s_col_f),
    .frameCollisions        (s_frame),
    .flipperHitCount        (s_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are read at the same point,
  // i.e. they show the result of the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic set_draw(input logic s, input logic f, input logic b);
    draw_smiley  = s;
    draw_flipper = f;
    draw_borders = b;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("reset_rgb",    32'(rgb_out),   32'h00);
    check("reset_col_b",  32'(col_b),     32'h0);
    check("reset_col_f",  32'(col_f),     32'h0);
    check("reset_frame",  32'(frame_col), 32'h0);
    check("reset_count",  32'(hit_cnt),   32'h0);
    check("reset_state",  32'(dut.state), 32'(ARMED));
    check("reset_scount", 32'(s_cnt),     32'h0);
    reset = 1'b0;

    // ---------------- RGB priority mux ----------------
    set_draw(1, 0, 0); tick();
    check("rgb_smiley", 32'(rgb_out), 32'hE0);
    set_draw(0, 0, 1); tick();
    check("rgb_borders", 32'(rgb_out), 32'h1F);
    set_draw(0, 0, 0); tick();
    check("rgb_background", 32'(rgb_out), 32'h03);
    set_draw(0, 1, 1); tick();
    check("rgb_flip_over_bord", 32'(rgb_out), 32'h1C);
    check("no_overlap_col_f", 32'(col_f), 32'h0);
    set_draw(0, 0, 0); tick();

    // ---------------- borders one-shot: 10-cycle overlap ----------------
    sof();
    check("frame_empty", 32'(frame_col), 32'h0);
    set_draw(1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bord_hold_%0d", i), 32'(col_b), (i == 0) ? 32'h1 : 32'h0);
    end
    set_draw(0, 0, 0); tick();
    check("bord_after", 32'(col_b), 32'h0);
    sof();
    check("frame_bord_only", 32'(frame_col), 32'h1);

    // ---------------- flipper holdoff over 8 frames ----------------
    for (int f = 0; f < 8; f++) begin
      logic hit;
      hit = (f == 0) || (f == 4);
      check($sformatf("fsm_state_f%0d", f), 32'(dut.state),
            hit ? 32'(ARMED) : 32'(HOLDOFF));
      set_draw(1, 1, 0); tick();
      check($sformatf("flip_pulse_f%0d", f), 32'(col_f), 32'(hit));
      check($sformatf("sat_pulse_f%0d", f), 32'(s_col_f), 32'h1);
      check($sformatf("sat_count_f%0d", f), 32'(s_cnt), (f >= 2) ? 32'd3 : 32'(f + 1));
      set_draw(0, 0, 0); tick();
      check($sformatf("flip_clear_f%0d", f), 32'(col_f), 32'h0);
      sof();
      check($sformatf("frame_col_f%0d", f), 32'(frame_col), hit ? 32'h2 : 32'h0);
    end
    check("flip_count_2", 32'(hit_cnt), 32'd2);
    check("fsm_rearmed", 32'(dut.state), 32'(ARMED));

    // ---------------- simultaneous borders + flipper ----------------
    set_draw(1, 1, 1); tick();
    check("both_col_b", 32'(col_b), 32'h1);
    check("both_col_f", 32'(col_f), 32'h1);
    check("both_rgb",   32'(rgb_out), 32'hE0);
    set_draw(0, 0, 0); tick();
    sof();
    check("frame_both",   32'(frame_col), 32'h3);
    check("flip_count_3", 32'(hit_cnt),   32'd3);

    // ---------------- overlap on the startOfFrame cycle ----------------
    set_draw(1, 0, 1); tick();
    check("old_frame_bord", 32'(col_b), 32'h1);
    set_draw(0, 0, 0); tick();
    set_draw(1, 0, 1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("sof_overlap_pulse", 32'(col_b), 32'h1);
    check("sof_overlap_frame", 32'(frame_col), 32'h1);
    tick();
    check("sof_overlap_blocked", 32'(col_b), 32'h0);
    check("holdoff_col_f", 32'(col_f), 32'h0);
    set_draw(0, 0, 0); tick();
    sof();
    check("new_frame_flag", 32'(frame_col), 32'h1);

    // ---------------- drive the hit counter to 100 ----------------
    // Holdoff ends at the next frame start; hits then land every 4th frame:
    // 385 frames give 97 more hits.
    for (int k = 0; k < 385; k++) begin
      sof();
      set_draw(1, 1, 0); tick();
      set_draw(0, 0, 0);
    end
    check("flip_count_100", 32'(hit_cnt),   32'd100);
    check("holdoff_at_100", 32'(dut.state), 32'(HOLDOFF));
    check("sat_count_hold", 32'(s_cnt),     32'd3);

    // ---------------- reset mid-holdoff, pulse in flight dropped ----------------
    reset = 1'b1;
    set_draw(1, 0, 1); tick();
    check("mid_reset_rgb",    32'(rgb_out),   32'h00);
    check("mid_reset_col_b",  32'(col_b),     32'h0);
    check("mid_reset_col_f",  32'(col_f),     32'h0);
    check("mid_reset_frame",  32'(frame_col), 32'h0);
    check("mid_reset_count",  32'(hit_cnt),   32'h0);
    check("mid_reset_state",  32'(dut.state), 32'(ARMED));
    check("mid_reset_scount", 32'(s_cnt),     32'h0);
    reset = 1'b0;
    set_draw(1, 1, 0); tick();
    check("post_reset_col_f", 32'(col_f),   32'h1);
    check("post_reset_col_b", 32'(col_b),   32'h0);
    check("post_reset_count", 32'(hit_cnt), 32'd1);
    check("post_reset_rgb",   32'(rgb_out), 32'hE0);
    set_draw(0, 0, 0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
